// File: rtl/apb_req_fifo_p.sv
// rtl/apb_req_fifo_p.sv - first-word-fall-through request FIFO between an APB slave and an arbiter
// Entries are {write, addr, wdata}; one shared read/write pointer pair with a wrap bit.
module apb_req_fifo_p #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_in,
    input  logic              push_in,
    input  logic              push_write_in,
    input  logic [ADDR_W-1:0] push_addr_in,
    input  logic [DATA_W-1:0] push_wdata_in,
    output logic              push_ack_o,
    input  logic              pop_in,
    output logic              pop_valid_o,
    output logic              pop_write_o,
    output logic [ADDR_W-1:0] pop_addr_o,
    output logic [DATA_W-1:0] pop_wdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] PTR_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

    logic              mem_write [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             push_acc;
    logic             pop_acc;
    logic             ovf_q;
    logic             unf_q;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    assign empty_o       = (wr_ptr == rd_ptr);
    assign full_o        = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign count_o       = wr_ptr - rd_ptr;
    assign almost_full_o = (count_o >= AFULL_CNT);
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;

    // Space freed by a same-cycle pop is not offered to the push.
    assign push_acc   = push_in && !full_o;
    assign pop_acc    = pop_in && !empty_o;
    assign push_ack_o = push_acc;

    assign pop_valid_o = !empty_o;
    assign pop_write_o = empty_o ? 1'b0 : mem_write[rd_idx];
    assign pop_addr_o  = empty_o ? '0 : mem_addr[rd_idx];
    assign pop_wdata_o = empty_o ? '0 : mem_wdata[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (clear_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_in && full_o) begin
                ovf_q <= 1'b1;
            end
            if (pop_in && empty_o) begin
                unf_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; read transfers store zero data so nothing stale leaks out.
    always_ff @(posedge clk) begin
        if (!reset && !clear_in && push_acc) begin
            mem_write[wr_idx] <= push_write_in;
            mem_addr[wr_idx]  <= push_addr_in;
            mem_wdata[wr_idx] <= push_write_in ? push_wdata_in : '0;
        end
    end

endmodule

// File: tb/tb_apb_req_fifo_p.sv
// tb/tb_apb_req_fifo_p.sv - directed self-checking bench for apb_req_fifo_p
// DEPTH=4, AFULL_TH=3; vector table plus wrap and reset sequences.
module tb_apb_req_fifo_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_in;
    logic        push_in;
    logic        push_write_in;
    logic [31:0] push_addr_in;
    logic [31:0] push_wdata_in;
    logic        push_ack_o;
    logic        pop_in;
    logic        pop_valid_o;
    logic        pop_write_o;
    logic [31:0] pop_addr_o;
    logic [31:0] pop_wdata_o;
    logic        full_o;
    logic        empty_o;
    logic        almost_full_o;
    logic [2:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;

    apb_req_fifo_p #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .AFULL_TH(3)) dut (
        .clk(clk), .reset(reset), .clear_in(clear_in),
        .push_in(push_in), .push_write_in(push_write_in),
        .push_addr_in(push_addr_in), .push_wdata_in(push_wdata_in),
        .push_ack_o(push_ack_o), .pop_in(pop_in), .pop_valid_o(pop_valid_o),
        .pop_write_o(pop_write_o), .pop_addr_o(pop_addr_o), .pop_wdata_o(pop_wdata_o),
        .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
        .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push, wr;
        logic [31:0] addr, wdata;
        logic        pop, clr;
        logic        e_ack, e_valid, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic        e_full, e_empty, e_af;
        logic [2:0]  e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    vec_t vec [20];
    ent_t q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic po, input logic c);
        push_in       = p;
        push_write_in = w;
        push_addr_in  = a;
        push_wdata_in = d;
        pop_in        = po;
        clear_in      = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag);
        chk({tag, " valid"}, 32'(pop_valid_o), 32'd1);
        chk({tag, " write"}, 32'(pop_write_o), 32'(q[0].w));
        chk({tag, " addr"}, pop_addr_o, q[0].a);
        chk({tag, " wdata"}, pop_wdata_o, q[0].d);
    endtask

    initial begin
        // push, wr, addr, wdata, pop, clr | ack, valid, wr, addr, wdata, full, empty, af, cnt, ovf, unf
        vec[0]  = '{0,0,32'h0, 32'h0, 0,0, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};
        vec[1]  = '{1,1,32'h10,32'hAA,0,0, 1,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};
        vec[2]  = '{1,0,32'h14,32'hFF,0,0, 1,1,1,32'h10,32'hAA,0,0,0,3'd1,0,0};
        vec[3]  = '{0,0,32'h0, 32'h0, 1,0, 0,1,1,32'h10,32'hAA,0,0,0,3'd2,0,0};
        vec[4]  = '{0,0,32'h0, 32'h0, 1,0, 0,1,0,32'h14,32'h0, 0,0,0,3'd1,0,0};
        vec[5]  = '{0,0,32'h0, 32'h0, 0,0, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};
        vec[6]  = '{1,1,32'h20,32'hB0,0,0, 1,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};
        vec[7]  = '{1,1,32'h21,32'hB1,0,0, 1,1,1,32'h20,32'hB0,0,0,0,3'd1,0,0};
        vec[8]  = '{1,1,32'h22,32'hB2,0,0, 1,1,1,32'h20,32'hB0,0,0,0,3'd2,0,0};
        vec[9]  = '{1,1,32'h23,32'hB3,0,0, 1,1,1,32'h20,32'hB0,0,0,1,3'd3,0,0};
        vec[10] = '{1,1,32'h24,32'hB4,0,0, 0,1,1,32'h20,32'hB0,1,0,1,3'd4,0,0};
        vec[11] = '{0,0,32'h0, 32'h0, 0,0, 0,1,1,32'h20,32'hB0,1,0,1,3'd4,1,0};
        vec[12] = '{1,1,32'h25,32'hB5,1,0, 0,1,1,32'h20,32'hB0,1,0,1,3'd4,1,0};
        vec[13] = '{0,0,32'h0, 32'h0, 0,0, 0,1,1,32'h21,32'hB1,0,0,1,3'd3,1,0};
        vec[14] = '{1,1,32'h26,32'hB6,0,1, 1,1,1,32'h21,32'hB1,0,0,1,3'd3,1,0};
        vec[15] = '{0,0,32'h0, 32'h0, 0,0, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};
        vec[16] = '{0,0,32'h0, 32'h0, 1,0, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};
        vec[17] = '{0,0,32'h0, 32'h0, 0,0, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,1};
        vec[18] = '{0,0,32'h0, 32'h0, 1,1, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,1};
        vec[19] = '{0,0,32'h0, 32'h0, 0,0, 0,0,0,32'h0, 32'h0, 0,1,0,3'd0,0,0};

        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vec[i].push, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].pop, vec[i].clr);
            @(negedge clk);
            chk($sformatf("v%0d ack", i),   32'(push_ack_o),    32'(vec[i].e_ack));
            chk($sformatf("v%0d valid", i), 32'(pop_valid_o),   32'(vec[i].e_valid));
            chk($sformatf("v%0d pwr", i),   32'(pop_write_o),   32'(vec[i].e_wr));
            chk($sformatf("v%0d paddr", i), pop_addr_o,         vec[i].e_addr);
            chk($sformatf("v%0d pdata", i), pop_wdata_o,        vec[i].e_wdata);
            chk($sformatf("v%0d full", i),  32'(full_o),        32'(vec[i].e_full));
            chk($sformatf("v%0d empty", i), 32'(empty_o),       32'(vec[i].e_empty));
            chk($sformatf("v%0d afull", i), 32'(almost_full_o), 32'(vec[i].e_af));
            chk($sformatf("v%0d count", i), 32'(count_o),       32'(vec[i].e_cnt));
            chk($sformatf("v%0d ovf", i),   32'(overflow_o),    32'(vec[i].e_ovf));
            chk($sformatf("v%0d unf", i),   32'(underflow_o),   32'(vec[i].e_unf));
            step();
        end

        // Steady push+pop at count 2; twelve pushes wrap both pointers.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'h40 + i, 32'hC0 + i, 0, 0);
            q.push_back('{w: 1'b1, a: 32'h40 + i, d: 32'hC0 + i});
            step();
        end
        for (int i = 0; i < 10; i++) begin
            logic wbit;
            ent_t e;
            wbit = 1'(i % 2);
            drive(1, wbit, 32'h80 + i, 32'hD0 + i, 1, 0);
            @(negedge clk);
            chk($sformatf("s%0d count", i), 32'(count_o), 32'd2);
            chk($sformatf("s%0d ack", i), 32'(push_ack_o), 32'd1);
            chk_head($sformatf("s%0d", i));
            e.w = wbit;
            e.a = 32'h80 + i;
            e.d = wbit ? 32'hD0 + i : 32'h0;
            void'(q.pop_front());
            q.push_back(e);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 32'h0, 1, 0);
            @(negedge clk);
            chk_head($sformatf("d%0d", i));
            void'(q.pop_front());
            step();
        end
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        chk("drain empty", 32'(empty_o), 32'd1);
        chk("drain unf", 32'(underflow_o), 32'd0);

        // Reset mid-stream at count 3 during a push discards everything.
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h50 + i, 32'hE0 + i, 0, 0);
            step();
        end
        drive(1, 1, 32'h53, 32'hE3, 0, 0);
        @(negedge clk);
        chk("pre-rst count", 32'(count_o), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        chk("rst count", 32'(count_o), 32'd0);
        chk("rst empty", 32'(empty_o), 32'd1);
        chk("rst valid", 32'(pop_valid_o), 32'd0);
        chk("rst paddr", pop_addr_o, 32'h0);
        step();
        drive(1, 1, 32'h60, 32'hF0, 0, 0);
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        chk("post-rst count", 32'(count_o), 32'd1);
        chk("post-rst addr", pop_addr_o, 32'h60);
        chk("post-rst wdata", pop_wdata_o, 32'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_req_fifo_p.md
APB_REQ_FIFO_P -- requirements
Module: apb_req_fifo_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address field width.
REQ-002 SHALL have parameter DATA_W, default 32: write-data field width.
REQ-003 SHALL have parameter DEPTH, default 8: entry count; power of 2, at least 2.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-1: almost-full threshold, 1 to DEPTH.
REQ-005 SHALL define CNT_W = $clog2(DEPTH)+1 as a local parameter.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port clear_in, input, 1: synchronous flush, active-high.
REQ-009 SHALL have port push_in, input, 1: push request from the APB slave.
REQ-010 SHALL have port push_write_in, input, 1: 1 = write transfer, 0 = read transfer.
REQ-011 SHALL have port push_addr_in, input, ADDR_W: transfer address.
REQ-012 SHALL have port push_wdata_in, input, DATA_W: write data, ignored for reads.
REQ-013 SHALL have port push_ack_o, output, 1: push accepted this cycle.
REQ-014 SHALL have port pop_in, input, 1: pop request from the arbiter.
REQ-015 SHALL have port pop_valid_o, output, 1: head entry valid.
REQ-016 SHALL have port pop_write_o, output, 1: head entry direction.
REQ-017 SHALL have port pop_addr_o, output, ADDR_W: head entry address.
REQ-018 SHALL have port pop_wdata_o, output, DATA_W: head entry write data.
REQ-019 SHALL have ports full_o, empty_o and almost_full_o, output, 1 each: status flags.
REQ-020 SHALL have port count_o, output, CNT_W: current occupancy.
REQ-021 SHALL have ports overflow_o and underflow_o, output, 1 each: sticky error flags.

Function
REQ-022 SHALL store each entry as the tuple {write, addr, wdata}, with a single read pointer and a single write pointer shared by all fields.
REQ-023 SHALL use pointers of width $clog2(DEPTH)+1, with the MSB acting as the wrap bit; full = index bits equal and wrap bits differ; empty = pointers equal.
REQ-024 SHALL drive push_ack_o = push_in && !full_o, where full_o is the registered pre-edge state; a pop in the same cycle does not free space for the push.
REQ-025 SHALL, on an accepted push, write the entry at the write pointer and increment the write pointer modulo 2*DEPTH on the next edge.
REQ-026 SHALL store wdata as 0 when push_write_in = 0, so that read entries never carry stale data.
REQ-027 SHALL be first-word-fall-through: pop_valid_o = !empty_o, and pop_write_o/pop_addr_o/pop_wdata_o show the head entry combinationally while valid, and drive 0 when empty.
REQ-028 SHALL accept a pop when pop_in && !empty_o, and increment the read pointer on the next edge.
REQ-029 SHALL, on a simultaneous accepted push and pop, move both pointers and leave count_o unchanged.
REQ-030 SHALL latency: a push into an empty FIFO makes pop_valid_o = 1 in the next cycle.
REQ-031 SHALL keep count_o equal to wr_ptr - rd_ptr (CNT_W bits), with range 0 to DEPTH.
REQ-032 SHALL drive almost_full_o = (count_o >= AFULL_TH).
REQ-033 SHALL set overflow_o when push_in && full_o; it holds until reset or clear_in.
REQ-034 SHALL set underflow_o when pop_in && empty_o; it holds until reset or clear_in, and pointers do not move.
REQ-035 SHALL, on clear_in, zero both pointers and both sticky flags on the next edge; clear_in overrides a same-cycle push or pop, and storage contents are don't-care.

Reset
REQ-036 SHALL, on reset, zero both pointers, overflow_o and underflow_o, giving empty_o = 1, full_o = 0, almost_full_o = 0, count_o = 0, pop_valid_o = 0 and pop_* outputs = 0.
REQ-037 SHALL take reset priority over clear_in, push and pop; reset mid-stream discards all entries.
REQ-038 SHALL not reset the storage array.

Verification (DEPTH=4, AFULL_TH=3)
REQ-039 SHALL verify: push W A=0x10 D=0xAA, then R A=0x14 D=0xFF -> pops return {1,0x10,0xAA} then {0,0x14,0x0}, in order.
REQ-040 SHALL verify: 4 pushes, no pop -> count_o 1,2,3,4; almost_full_o rises at count 3; full_o = 1; a 5th push gives push_ack_o = 0 and overflow_o = 1.
REQ-041 SHALL verify: full, push+pop in the same cycle -> pop accepted, push rejected, count_o = 3.
REQ-042 SHALL verify: count 2, push+pop every cycle for 10 cycles -> count_o stays 2, pointers wrap, FIFO order is preserved.
REQ-043 SHALL verify: pop_in while empty -> underflow_o = 1, pop_valid_o = 0; a subsequent clear_in clears underflow_o.
REQ-044 SHALL verify: reset asserted at count 3 during a push -> next cycle count_o = 0, empty_o = 1, and the pushed entry is lost.
